pls_dac_stream_sink: RTL and testbench
======================================

# pls_dac_stream_sink

Receiving end of the generator's sample stream. Accepts samples as an AXI-Stream slave, buffers them in a small FIFO and releases one sample to the DAC data bus every `rate_div+1` clocks. It primes the buffer before starting playout and flags underruns with a sticky status bit. It sits between the generator FSM's `maxis_signal` output and the DAC pin/serializer logic.

## Interface
- `DATA_SIZE`, 32: stream sample width.
- `DAC_WIDTH`, 16: DAC word width, must be ≤ `DATA_SIZE`.
- `FIFO_DEPTH`, 8: buffer entries, power of two, ≥ 2.
- `PRIME_LEVEL`, 4: FIFO level required before playout starts, 1..`FIFO_DEPTH`.
- `DIV_WIDTH`, 16: width of the rate divider.

Ports (`LW = $clog2(FIFO_DEPTH)+1`):
- `aclk`  in  1  clock, single clock domain.
- `areset`  in  1  reset, asynchronous, active-high.
- `saxis_tdata`  in  `DATA_SIZE`  sample.
- `saxis_tvalid`  in  1  sample valid.
- `saxis_tlast`  in  1  accepted, ignored; the generator asserts it on every beat.
- `saxis_tready`  out  1  sink can accept a sample.
- `enable`  in  1  level: run playout; 0 flushes and stops.
- `rate_div`  in  `DIV_WIDTH`  output period minus 1, in clocks.
- `clear_status`  in  1  pulse: clears `underrun` and `sample_count`.
- `dac_data`  out  `DAC_WIDTH`  current DAC word.
- `dac_strobe`  out  1  one-cycle pulse; `dac_data` was updated this cycle.
- `underrun`  out  1  sticky: a tick occurred with the FIFO empty.
- `fifo_level`  out  `LW`  entries currently stored.
- `sample_count`  out  32  samples played since the last clear; wraps.

## Operation
- Data conversion: `dac_data <= fifo_head[DATA_SIZE-1 -: DAC_WIDTH]`, taking the MSBs with no rounding or saturation.
- Push: when `saxis_tvalid & saxis_tready`, the sample is written to the FIFO.
- `saxis_tready = (state != IDLE) & !full`. It depends only on registers; there is no path from `tvalid` to `tready`.
- If the FIFO is full and a pop occurs in the same cycle, `tready` stays 0 that cycle. No push-through when full.
- FSM states:
  - `IDLE`: FIFO held empty (pointers reset every cycle); `dac_data` holds its last value. Go to `FILL` when `enable`=1.
  - `FILL`: accepts samples, no playout. Go to `RUN` when `fifo_level >= PRIME_LEVEL`. `rate_div` is captured into `div_q` on this transition.
  - `RUN`: down-counter `tick_cnt` is 0 on entry. A tick occurs when `tick_cnt==0`, then `tick_cnt` reloads to `div_q`; otherwise it decrements.
    - Tick with FIFO not empty: pop the sample.
    - Tick with FIFO empty: set `underrun`, hold `dac_data`, no strobe, go to `FILL`.
  - From any state, `enable`=0 sends the FSM to `IDLE` on the next clock and the FIFO is flushed. A tick in that same cycle is still served.
- `rate_div` changes during `RUN` are ignored until the next `FILL`→`RUN` transition.
- `sample_count` increments on each `dac_strobe` and wraps from 2^32-1 to 0.
- `clear_status` zeroes `underrun` and `sample_count`. If it coincides with an underrun or a strobe, the set/increment wins: `underrun`=1, `sample_count`=1.
- `fifo_level` is registered. It reflects push and pop one clock after they occur; a simultaneous push and pop leaves it unchanged.

## Timing
- Reset values (asserted asynchronously):
  - state `IDLE`, `saxis_tready`=0, `dac_data`=0, `dac_strobe`=0, `underrun`=0, `fifo_level`=0, `sample_count`=0.
  - `tick_cnt`=0, `div_q`=0.
- Reset mid-operation discards the FIFO contents and status immediately. After release the block restarts from `IDLE`.
- Push-to-level latency: 1 clock.
- `FILL`→`RUN`: 1 clock after `fifo_level` reaches `PRIME_LEVEL`.
- First tick occurs in the first `RUN` cycle. `dac_data` and `dac_strobe` are registered, so they appear 1 clock after the tick.
- Steady-state strobe period is `div_q+1` clocks; `div_q`=0 gives a strobe every clock.
- `enable` deassert: `saxis_tready` drops 1 clock later (on entry to `IDLE`), and `fifo_level` reads 0 the clock after that.

## Test plan
- Prime and play: `PRIME_LEVEL`=4, `rate_div`=3; push 0x1234_0000, 0x2345_0000, 0x3456_0000, 0x4567_0000 back-to-back → no strobe before `fifo_level`=4. Then strobes every 4 clocks with `dac_data` 0x1234, 0x2345, 0x3456, 0x4567; `sample_count`=4.
- Full back-pressure: `rate_div`=15, push 10 samples continuously → `saxis_tready`=0 while `fifo_level`=8. No sample is lost or duplicated and the output order matches the input order.
- Underrun: push 4 samples, then stop `tvalid` with `rate_div`=0 → 4 strobes on consecutive clocks, then `underrun`=1. `dac_data` holds the 4th word and the FSM re-enters `FILL`. Pushing 4 more resumes playout.
- Max rate streaming: `rate_div`=0 with a generator-like source (1 beat per 4 clocks) → underrun occurs. Repeat with `rate_div`=7 → 100 samples play with `underrun`=0 and the strobe period is exactly 8.
- Disable and clear: deassert `enable` mid-`RUN` with 5 buffered → `tready`=0 next clock, `fifo_level`=0 within 2 clocks, no further strobes. `clear_status` in the same cycle as an underrun leaves `underrun`=1.
- Async reset mid-`RUN` (asserted between clock edges) → all outputs take their reset values immediately. After release, `enable`=1 restarts from `FILL`.

Source files
------------

// File: rtl/pls_dac_stream_sink.sv
// pls_dac_stream_sink: AXI-Stream sample sink that primes a FIFO and plays one DAC word every rate_div+1 clocks.
module pls_dac_stream_sink #(
  parameter int DATA_SIZE   = 32,
  parameter int DAC_WIDTH   = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int PRIME_LEVEL = 4,
  parameter int DIV_WIDTH   = 16,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int LW = AW + 1
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [DATA_SIZE-1:0] saxis_tdata,
  input  logic                 saxis_tvalid,
  input  logic                 saxis_tlast,
  output logic                 saxis_tready,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] rate_div,
  input  logic                 clear_status,
  output logic [DAC_WIDTH-1:0] dac_data,
  output logic                 dac_strobe,
  output logic                 underrun,
  output logic [LW-1:0]        fifo_level,
  output logic [31:0]          sample_count
);
  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
  state_t r_state, w_next;
  logic [DAC_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [LW-1:0] r_level;
  logic [DIV_WIDTH-1:0] r_div, r_tick;
  logic [DAC_WIDTH-1:0] r_dac;
  logic r_strobe, r_underrun;
  logic [31:0] r_count;
  logic w_full, w_empty, w_push, w_tick, w_pop, w_under, w_unused;
  assign w_full       = r_level == LW'(FIFO_DEPTH);
  assign w_empty      = r_level == '0;
  assign saxis_tready = (r_state != IDLE) & ~w_full;
  assign w_push       = saxis_tvalid & saxis_tready;
  assign w_tick       = (r_state == RUN) & (r_tick == '0);
  assign w_pop        = w_tick & ~w_empty;
  assign w_under      = w_tick & w_empty;
  assign w_unused     = ^{saxis_tlast, saxis_tdata};
  always_comb
    w_next = !enable ? IDLE :
             (r_state == IDLE) ? FILL :
             (r_state == FILL) ? ((r_level >= LW'(PRIME_LEVEL)) ? RUN : FILL) :
             (w_under ? FILL : RUN);
  // Only the DAC slice of each sample is ever played, so only that slice is stored.
  always_ff @(posedge aclk)
    if (w_push) r_mem[r_wr] <= saxis_tdata[DATA_SIZE-1 -: DAC_WIDTH];
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      r_state    <= IDLE;
      r_wr       <= '0;
      r_rd       <= '0;
      r_level    <= '0;
      r_div      <= '0;
      r_tick     <= '0;
      r_dac      <= '0;
      r_strobe   <= 1'b0;
      r_underrun <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state    <= w_next;
      r_wr       <= (r_state == IDLE) ? '0 : r_wr + AW'(w_push);
      r_rd       <= (r_state == IDLE) ? '0 : r_rd + AW'(w_pop);
      r_level    <= (r_state == IDLE) ? '0 : r_level + LW'(w_push) - LW'(w_pop);
      r_tick     <= (r_state != RUN || w_next != RUN) ? '0 : w_tick ? r_div : r_tick - DIV_WIDTH'(1);
      r_div      <= (r_state == FILL && w_next == RUN) ? rate_div : r_div;
      r_dac      <= w_pop ? r_mem[r_rd] : r_dac;
      r_strobe   <= w_pop;
      r_underrun <= w_under | (r_underrun & ~clear_status);
      r_count    <= (clear_status ? '0 : r_count) + 32'(w_pop);
    end
  assign dac_data     = r_dac;
  assign dac_strobe   = r_strobe;
  assign underrun     = r_underrun;
  assign fifo_level   = r_level;
  assign sample_count = r_count;
endmodule

// File: tb/tb_pls_dac_stream_sink.sv
// tb_pls_dac_stream_sink: directed table and sequence checks for the DAC stream sink.
module tb_pls_dac_stream_sink;
  logic aclk, areset, saxis_tvalid, saxis_tready, enable, clear_status;
  logic saxis_tlast = 1'b1;
  logic [31:0] saxis_tdata;
  logic [15:0] rate_div, dac_data;
  logic dac_strobe, underrun;
  logic [3:0] fifo_level;
  logic [31:0] sample_count;
  pls_dac_stream_sink dut (
    .aclk(aclk), .areset(areset), .saxis_tdata(saxis_tdata), .saxis_tvalid(saxis_tvalid),
    .saxis_tlast(saxis_tlast), .saxis_tready(saxis_tready), .enable(enable), .rate_div(rate_div),
    .clear_status(clear_status), .dac_data(dac_data), .dac_strobe(dac_strobe), .underrun(underrun),
    .fifo_level(fifo_level), .sample_count(sample_count)
  );
  typedef struct {
    logic en, vld; logic [31:0] d; logic clr;
    logic stb; logic [15:0] dac; logic [3:0] lvl; logic rdy, und; logic [31:0] cnt;
  } vec_t;
  vec_t tbl[$];
  int n_cmp, n_err, cyc, pushed, n_stb, last_stb, gap_chk;
  bit rdy_chk, saw_full;
  logic [15:0] sb[$];
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  function automatic vec_t mk(input logic en, input logic vld, input logic [31:0] d, input logic clr,
                              input logic stb, input logic [15:0] dac, input logic [3:0] lvl,
                              input logic rdy, input logic und, input logic [31:0] cnt);
    mk = '{en, vld, d, clr, stb, dac, lvl, rdy, und, cnt};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic do_reset();
    areset = 1'b1; enable = 1'b0; saxis_tvalid = 1'b0; saxis_tdata = '0; clear_status = 1'b0;
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    sb.delete(); pushed = 0; n_stb = 0; last_stb = -1; gap_chk = 0; rdy_chk = 0; saw_full = 0;
  endtask
  task automatic tick_clk();
    logic acc;
    logic [15:0] e;
    acc = saxis_tvalid & saxis_tready & ~areset;
    @(posedge aclk);
    #1 cyc++;
    if (acc) begin
      sb.push_back(saxis_tdata[31:16]);
      pushed++;
    end
    if (dac_strobe) begin
      n_stb++;
      e = 'x;
      if (sb.size() > 0) e = sb.pop_front();
      chk("order", dac_data, e);
      if (gap_chk > 0 && last_stb >= 0) chk("strobe_period", cyc - last_stb, gap_chk);
      last_stb = cyc;
    end
    if (rdy_chk) begin
      chk("tready_vs_full", saxis_tready, fifo_level != 4'd8);
      saw_full |= (fifo_level == 4'd8);
    end
  endtask
  // Source: one beat, then gap-1 idle clocks after each accepted beat; holds data under back-pressure.
  task automatic src_run(input int n, input int gap, input int stop, input int budget, input logic [15:0] base);
    int gc = 0;
    for (int i = 0; i < budget && n_stb < stop; i++) begin
      int p;
      saxis_tvalid = (pushed < n) && gc == 0;
      saxis_tdata = {base + 16'(pushed), 16'(pushed * 7 + 3)};
      p = pushed;
      tick_clk();
      if (pushed != p) gc = gap - 1;
      else if (gc > 0) gc--;
    end
    saxis_tvalid = 1'b0;
  endtask
  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; rate_div = '0;
    do_reset();
    chk("rst_tready", saxis_tready, 0); chk("rst_dac", dac_data, 0); chk("rst_strobe", dac_strobe, 0);
    chk("rst_underrun", underrun, 0); chk("rst_level", fifo_level, 0); chk("rst_count", sample_count, 0);
    // Prime and play at rate_div=3, ending in an underrun and a disable/clear.
    tbl.push_back(mk(1, 1, 32'h1234_0000, 0, 0, 16'h0000, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 32'h1234_0000, 0, 0, 16'h0000, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 32'h2345_0000, 0, 0, 16'h0000, 2, 1, 0, 0));
    tbl.push_back(mk(1, 1, 32'h3456_0000, 0, 0, 16'h0000, 3, 1, 0, 0));
    tbl.push_back(mk(1, 1, 32'h4567_0000, 0, 0, 16'h0000, 4, 1, 0, 0));
    tbl.push_back(mk(1, 0, 32'h0, 0, 0, 16'h0000, 4, 1, 0, 0));
    tbl.push_back(mk(1, 0, 32'h0, 0, 1, 16'h1234, 3, 1, 0, 1));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1, 0, 32'h0, 0, 0, 16'h1234, 3, 1, 0, 1));
    tbl.push_back(mk(1, 0, 32'h0, 0, 1, 16'h2345, 2, 1, 0, 2));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1, 0, 32'h0, 0, 0, 16'h2345, 2, 1, 0, 2));
    tbl.push_back(mk(1, 0, 32'h0, 0, 1, 16'h3456, 1, 1, 0, 3));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1, 0, 32'h0, 0, 0, 16'h3456, 1, 1, 0, 3));
    tbl.push_back(mk(1, 0, 32'h0, 0, 1, 16'h4567, 0, 1, 0, 4));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1, 0, 32'h0, 0, 0, 16'h4567, 0, 1, 0, 4));
    tbl.push_back(mk(1, 0, 32'h0, 0, 0, 16'h4567, 0, 1, 1, 4));
    tbl.push_back(mk(0, 0, 32'h0, 0, 0, 16'h4567, 0, 0, 1, 4));
    tbl.push_back(mk(0, 0, 32'h0, 1, 0, 16'h4567, 0, 0, 0, 0));
    rate_div = 16'd3;
    for (int i = 0; i < tbl.size(); i++) begin
      enable = tbl[i].en; saxis_tvalid = tbl[i].vld; saxis_tdata = tbl[i].d; clear_status = tbl[i].clr;
      @(posedge aclk);
      #1;
      chk($sformatf("tbl%0d_strobe", i), dac_strobe, tbl[i].stb);
      chk($sformatf("tbl%0d_dac", i), dac_data, tbl[i].dac);
      chk($sformatf("tbl%0d_level", i), fifo_level, tbl[i].lvl);
      chk($sformatf("tbl%0d_tready", i), saxis_tready, tbl[i].rdy);
      chk($sformatf("tbl%0d_underrun", i), underrun, tbl[i].und);
      chk($sformatf("tbl%0d_count", i), sample_count, tbl[i].cnt);
    end
    // Full back-pressure
    do_reset(); rate_div = 16'd15; enable = 1'b1; rdy_chk = 1;
    src_run(10, 1, 10, 600, 16'hA000);
    rdy_chk = 0;
    chk("bp_strobes", n_stb, 10); chk("bp_saw_full", saw_full, 1);
    chk("bp_leftover", sb.size(), 0); chk("bp_count", sample_count, 10);
    // Underrun at rate_div=0, with clear_status landing on the underrun tick
    do_reset(); rate_div = 16'd0; enable = 1'b1; gap_chk = 1;
    src_run(4, 1, 4, 60, 16'hB000);
    gap_chk = 0;
    chk("ur_strobes", n_stb, 4);
    clear_status = 1'b1; tick_clk(); clear_status = 1'b0;
    chk("ur_flag_wins", underrun, 1); chk("ur_no_strobe", dac_strobe, 0);
    chk("ur_dac_hold", dac_data, 16'hB003); chk("ur_count_cleared", sample_count, 0);
    repeat (3) tick_clk();
    chk("ur_fill_tready", saxis_tready, 1); chk("ur_no_play", n_stb, 4);
    clear_status = 1'b1; tick_clk(); clear_status = 1'b0;
    chk("ur_cleared", underrun, 0);
    last_stb = -1; gap_chk = 1;
    src_run(8, 1, 8, 60, 16'hB000);
    gap_chk = 0;
    chk("ur_resume_strobes", n_stb, 8); chk("ur_resume_count", sample_count, 4);
    // Max rate vs a 1-in-4 source, then a sustainable rate_div=7
    do_reset(); rate_div = 16'd0; enable = 1'b1;
    src_run(12, 4, 1000, 80, 16'hC000);
    chk("mr_underrun", underrun, 1);
    enable = 1'b0; tick_clk(); tick_clk(); sb.delete();
    clear_status = 1'b1; tick_clk(); clear_status = 1'b0;
    chk("mr_cleared", underrun, 0); chk("mr_flushed", fifo_level, 0);
    pushed = 0; n_stb = 0; last_stb = -1; rate_div = 16'd7; enable = 1'b1; gap_chk = 8;
    src_run(100, 4, 100, 1200, 16'hD000);
    gap_chk = 0;
    chk("mr_strobes", n_stb, 100); chk("mr_no_underrun", underrun, 0); chk("mr_count", sample_count, 100);
    // Disable mid-RUN with 5 buffered
    do_reset(); rate_div = 16'd15; enable = 1'b1;
    src_run(6, 1, 1, 40, 16'hE000);
    chk("dis_level5", fifo_level, 5);
    enable = 1'b0; tick_clk();
    chk("dis_tready", saxis_tready, 0);
    tick_clk();
    chk("dis_level0", fifo_level, 0);
    repeat (20) tick_clk();
    chk("dis_no_strobe", n_stb, 1); chk("dis_dac_hold", dac_data, 16'hE000);
    // Asynchronous reset between clock edges while a strobe is showing
    do_reset(); rate_div = 16'd1; enable = 1'b1;
    src_run(6, 1, 2, 40, 16'hF000);
    chk("ar_pre_strobe", dac_strobe, 1);
    #2 areset = 1'b1;
    #1;
    chk("ar_strobe", dac_strobe, 0); chk("ar_dac", dac_data, 0); chk("ar_level", fifo_level, 0);
    chk("ar_count", sample_count, 0); chk("ar_tready", saxis_tready, 0); chk("ar_underrun", underrun, 0);
    #2 areset = 1'b0;
    sb.delete(); pushed = 0; n_stb = 0; last_stb = -1;
    tick_clk();
    chk("ar_fill_tready", saxis_tready, 1); chk("ar_fill_level", fifo_level, 0);
    src_run(4, 1, 1, 30, 16'h1000);
    chk("ar_restart_strobe", n_stb, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
